hi_lo_unit: RTL and testbench
=============================

# hi_lo_unit

Multiply/divide unit that owns the architectural HI and LO registers and supplies ReadDataHi/ReadDataLo to the write-back stage for MFHI/MFLO. It executes MULT/MULTU in one cycle, DIV/DIVU iteratively over 33 cycles, and handles MTHI/MTLO. It raises Busy so the hazard unit stalls any HI/LO consumer or producer until the result is committed.

## Interface
- No parameters; widths are fixed at 32-bit operands and 64-bit HI:LO.
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Start  in  1  Op/A/B valid this cycle
- Op  in  4  operation code (hi_lo_pkg): MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9; others are no-ops
- A  in  32  rs operand (dividend, multiplicand, MTHI/MTLO source)
- B  in  32  rt operand (divisor, multiplier)
- ReadDataHi  out  32  HI register
- ReadDataLo  out  32  LO register
- Busy  out  1  division in progress; Start is ignored while high
- DivByZero  out  1  one-cycle pulse on DIV/DIVU with B=0

## Operation
- Reset: HI=0, LO=0, Busy=0, DivByZero=0, state IDLE; any division in progress is aborted.
- States: IDLE, DIV_RUN (32 iterations), DIV_FIX (sign correction and commit).
- IDLE with Start=1:
  - MULT/MULTU: signed/unsigned 32x32 to 64-bit product; HI:LO ← product. Stays in IDLE.
  - MTHI: HI ← A, LO unchanged. MTLO: LO ← A, HI unchanged.
  - DIV/DIVU with B≠0: latch |A| and |B| (raw values for DIVU), the dividend sign, and the quotient sign, then go to DIV_RUN with counter=0.
  - DIV/DIVU with B=0: HI ← A, LO ← 0xFFFFFFFF, DivByZero=1 for one cycle. Stays in IDLE.
  - Undefined Op: no effect.
- DIV_RUN: one restoring shift-subtract step per cycle on a 32-bit remainder and 32-bit quotient. After step 31, go to DIV_FIX.
- DIV_FIX:
  - LO ← quotient, negated if the signs differed (signed only).
  - HI ← remainder, negated if the dividend was negative (signed only).
  - Go to IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 with no special case.
- Start while Busy=1 is ignored entirely; the pipeline must stall.
- HI/LO hold their values across DIV_RUN; the old values stay readable until the commit.

## Timing
- Start accepted at cycle n.
- MULT/MTHI/MTLO/MADD: registers written at the end of cycle n; the new value is visible in cycle n+1. Busy stays 0.
- DIV/DIVU: Busy=1 in cycles n+1 through n+33 (32 in DIV_RUN, 1 in DIV_FIX). The result is visible and Busy=0 in cycle n+34.
- DivByZero is high in cycle n+1 only.
- Busy is a registered output, decoded from state ≠ IDLE.
- Rst asserted in any cycle overrides Start and state. All outputs hold reset values from the following cycle.

## Configuration
- HI_LO_MADD_EN defined:
  - MADD/MADDU: HI:LO ← HI:LO + (A×B).
  - MSUB/MSUBU: HI:LO ← HI:LO − (A×B).
  - Signed or unsigned product, 64-bit wrap-around, single cycle like MULT.
- Not defined: Op codes 6–9 are no-ops and the accumulate adder is not built.

## Structure
- hi_lo_pkg holds:
  - Op code localparams
  - state encoding (IDLE, DIV_RUN, DIV_FIX)
  - DIV_ITERS=32
  - DIV0_LO=32'hFFFFFFFF
- Sub-module hilo_divider: iteration datapath (remainder/quotient registers, one restoring step, counter, done flag). hi_lo_unit holds the FSM, the multiplier, sign handling, and the HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFE, B=3 → cycle n+1: HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy never high. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → Busy high for exactly 33 cycles; at n+34: LO=0xFFFFFFFD, HI=0xFFFFFFFF. MTHI 0x55 issued at n+5 is ignored; HI is not 0x55.
- DIVU A=0, B=0 → DivByZero high for one cycle, HI=0, LO=0xFFFFFFFF, Busy stays 0. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100/7 with Rst asserted at the 10th Busy cycle → the next cycle shows HI=0, LO=0, Busy=0. A following MTLO 0x1234 → LO=0x1234 one cycle later.
- With HI_LO_MADD_EN: HI:LO=0x00000000:0xFFFFFFFF, MADDU A=1, B=1 → HI=1, LO=0; then MSUB A=1, B=2 → HI=0, LO=0xFFFFFFFE. Without the macro, the same sequence leaves HI:LO unchanged.
- Back-to-back MULT at n and MTLO at n+1 → n+1 shows the product; n+2 shows LO=A of MTLO and HI still from the product.

Source files
------------

// File: rtl/hi_lo_pkg.sv
// rtl/hi_lo_pkg.sv - op codes, FSM encoding and constants for hi_lo_unit
package hi_lo_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] DIV0_LO   = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } unitState_t;

    function automatic logic isSignedOp(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_divider.sv
// rtl/hilo_divider.sv - unsigned restoring divider datapath, one quotient bit per step
module hilo_divider
    import hi_lo_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] divisorReg;
    logic [4:0]  count;
    logic [32:0] partial;
    logic [32:0] trial;

    // Remainder is always below the divisor, so the shifted value fits in 33 bits
    // and bit 32 of the trial difference is a clean borrow.
    always_comb begin
        partial = {remainder, quotient[31]};
        trial   = partial - {1'b0, divisorReg};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            quotient   <= 32'd0;
            remainder  <= 32'd0;
            divisorReg <= 32'd0;
            count      <= 5'd0;
        end else if (load) begin
            quotient   <= dividend;
            remainder  <= 32'd0;
            divisorReg <= divisor;
            count      <= 5'd0;
        end else if (step) begin
            if (!trial[32]) begin
                remainder <= trial[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= partial[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            count <= count + 5'd1;
        end
    end

    assign done = step && (count == 5'(DIV_ITERS - 1));

endmodule

// File: rtl/hi_lo_unit.sv
// rtl/hi_lo_unit.sv - HI/LO multiply/divide unit; HI_LO_MADD_EN adds MADD/MSUB accumulate
module hi_lo_unit
    import hi_lo_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ReadDataHi,
    output logic [31:0] ReadDataLo,
    output logic        Busy,
    output logic        DivByZero
);

    unitState_t  state;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        negQuot;
    logic        negRem;

    logic        opSigned;
    logic        isDivOp;
    logic [63:0] mulA;
    logic [63:0] mulB;
    logic [63:0] product;
    logic [31:0] absA;
    logic [31:0] absB;
    logic        divLoad;
    logic        divStep;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divDone;

    // Sign-extending for signed ops lets one 64-bit multiplier serve both flavours.
    always_comb begin
        opSigned = isSignedOp(Op);
        isDivOp  = (Op == OP_DIV) || (Op == OP_DIVU);
        mulA     = {{32{opSigned & A[31]}}, A};
        mulB     = {{32{opSigned & B[31]}}, B};
        product  = mulA * mulB;
        absA     = (opSigned && A[31]) ? (32'd0 - A) : A;
        absB     = (opSigned && B[31]) ? (32'd0 - B) : B;
        divLoad  = (state == IDLE) && Start && isDivOp && (B != 32'd0);
        divStep  = (state == DIV_RUN);
    end

`ifdef HI_LO_MADD_EN
    logic [63:0] hiLo;
    assign hiLo = {hiReg, loReg};
`endif

    hilo_divider u_divider (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (divLoad),
        .step      (divStep),
        .dividend  (absA),
        .divisor   (absB),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (divDone)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            hiReg     <= 32'd0;
            loReg     <= 32'd0;
            negQuot   <= 1'b0;
            negRem    <= 1'b0;
            Busy      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MULT, OP_MULTU: {hiReg, loReg} <= product;
                            OP_MTHI:           hiReg <= A;
                            OP_MTLO:           loReg <= A;
                            OP_DIV, OP_DIVU: begin
                                if (B == 32'd0) begin
                                    hiReg     <= A;
                                    loReg     <= DIV0_LO;
                                    DivByZero <= 1'b1;
                                end else begin
                                    negQuot <= opSigned && (A[31] ^ B[31]);
                                    negRem  <= opSigned && A[31];
                                    state   <= DIV_RUN;
                                    Busy    <= 1'b1;
                                end
                            end
`ifdef HI_LO_MADD_EN
                            OP_MADD, OP_MADDU: {hiReg, loReg} <= hiLo + product;
                            OP_MSUB, OP_MSUBU: {hiReg, loReg} <= hiLo - product;
`endif
                            default: ;
                        endcase
                    end
                end
                DIV_RUN: begin
                    if (divDone) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    loReg <= negQuot ? (32'd0 - quotient) : quotient;
                    hiReg <= negRem ? (32'd0 - remainder) : remainder;
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ReadDataHi = hiReg;
    assign ReadDataLo = loReg;

endmodule

// File: tb/tb_hi_lo_unit.sv
// tb/tb_hi_lo_unit.sv - self-checking bench for hi_lo_unit (honours HI_LO_MADD_EN)
module tb_hi_lo_unit;
    import hi_lo_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ReadDataHi;
    logic [31:0] ReadDataLo;
    logic        Busy;
    logic        DivByZero;

    int checks = 0;
    int errors = 0;

    hi_lo_unit dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Op         (Op),
        .A          (A),
        .B          (B),
        .ReadDataHi (ReadDataHi),
        .ReadDataLo (ReadDataLo),
        .Busy       (Busy),
        .DivByZero  (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural HI/LO plus a countdown of busy cycles and the
    // quotient/remainder that appears when the countdown expires.
    logic [31:0] mHi, mLo, pHi, pLo;
    int          mLeft;
    logic        mDbz;
    logic        mValid = 1'b0;

    always @(posedge Clk) begin : model
        logic [31:0]     nHi, nLo, nPHi, nPLo;
        int              nLeft;
        logic            nDbz;
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, prod, acc;
        nHi = mHi; nLo = mLo; nPHi = pHi; nPLo = pLo; nLeft = mLeft; nDbz = 1'b0;
        sa = $signed(A); sb = $signed(B); ua = A; ub = B;
        prod = isSignedOp(Op) ? longint'(sa * sb) : ua * ub;
        if (Rst) begin
            nHi = 0; nLo = 0; nLeft = 0;
        end else if (mLeft > 0) begin
            nLeft = mLeft - 1;
            if (nLeft == 0) begin nHi = pHi; nLo = pLo; end
        end else if (Start) begin
            case (Op)
                OP_MULT, OP_MULTU: {nHi, nLo} = prod;
                OP_MTHI: nHi = A;
                OP_MTLO: nLo = A;
                OP_DIV, OP_DIVU: begin
                    if (B == 0) begin
                        nHi = A; nLo = 32'hFFFFFFFF; nDbz = 1'b1;
                    end else begin
                        if (Op == OP_DIV) begin sq = sa / sb; sr = sa % sb; end
                        else begin sq = longint'(ua / ub); sr = longint'(ua % ub); end
                        nPLo = 32'(sq); nPHi = 32'(sr); nLeft = 33;
                    end
                end
`ifdef HI_LO_MADD_EN
                OP_MADD, OP_MADDU: begin acc = {mHi, mLo}; {nHi, nLo} = acc + prod; end
                OP_MSUB, OP_MSUBU: begin acc = {mHi, mLo}; {nHi, nLo} = acc - prod; end
`endif
                default: ;
            endcase
        end
        mHi <= nHi; mLo <= nLo; pHi <= nPHi; pLo <= nPLo; mLeft <= nLeft; mDbz <= nDbz;
        if (Rst) mValid <= 1'b1;
    end

    always @(negedge Clk) begin
        if (mValid) begin
            check("model_hi", ReadDataHi, mHi);
            check("model_lo", ReadDataLo, mLo);
            check("model_busy", {31'd0, Busy}, {31'd0, mLeft != 0});
            check("model_dbz", {31'd0, DivByZero}, {31'd0, mDbz});
        end
    end

    // Presents one operation for a single cycle; returns at the middle of cycle n+1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge Clk);
        end
    endtask

    int cnt;

    initial begin
        Rst = 1'b1; Start = 1'b0; Op = 4'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge Clk);
        check("rst_hi", ReadDataHi, 32'h0);
        check("rst_lo", ReadDataLo, 32'h0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        Rst = 1'b0;

        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        check("mult_hi", ReadDataHi, 32'hFFFFFFFF);
        check("mult_lo", ReadDataLo, 32'hFFFFFFFA);
        check("mult_busy", {31'd0, Busy}, 32'd0);
        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
        check("multu_hi", ReadDataHi, 32'h2);
        check("multu_lo", ReadDataLo, 32'hFFFFFFFA);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            cnt++;
            Start = (cnt == 5); Op = OP_MTHI; A = 32'h55; B = 32'd0;
            @(negedge Clk);
        end
        Start = 1'b0;
        check("div_busy_cycles", cnt, 32'd33);
        check("div_lo", ReadDataLo, 32'hFFFFFFFD);
        check("div_hi", ReadDataHi, 32'hFFFFFFFF);

        issue(OP_DIVU, 32'd0, 32'd0);
        check("dbz_pulse", {31'd0, DivByZero}, 32'd1);
        check("dbz_hi", ReadDataHi, 32'h0);
        check("dbz_lo", ReadDataLo, 32'hFFFFFFFF);
        check("dbz_busy", {31'd0, Busy}, 32'd0);
        @(negedge Clk);
        check("dbz_end", {31'd0, DivByZero}, 32'd0);

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(cnt);
        check("ovf_lo", ReadDataLo, 32'h80000000);
        check("ovf_hi", ReadDataHi, 32'h0);

        issue(OP_DIVU, 32'd100, 32'd7);
        waitIdle(cnt);
        check("divu_lo", ReadDataLo, 32'd14);
        check("divu_hi", ReadDataHi, 32'd2);

        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        waitIdle(cnt);
        check("div_negb_lo", ReadDataLo, 32'hFFFFFFFD);
        check("div_negb_hi", ReadDataHi, 32'd1);

        issue(OP_DIVU, 32'hFFFFFFFF, 32'd10);
        waitIdle(cnt);
        check("divu_big_lo", ReadDataLo, 32'h19999999);
        check("divu_big_hi", ReadDataHi, 32'd5);

        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (8) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("abort_hi", ReadDataHi, 32'h0);
        check("abort_lo", ReadDataLo, 32'h0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        issue(OP_MTLO, 32'h1234, 32'd0);
        check("mtlo_after_rst", ReadDataLo, 32'h1234);

        issue(4'hF, 32'hDEAD, 32'hBEEF);
        check("undef_lo", ReadDataLo, 32'h1234);

        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFFFFFF, 32'd0);
        issue(OP_MADDU, 32'd1, 32'd1);
`ifdef HI_LO_MADD_EN
        check("maddu_hi", ReadDataHi, 32'd1);
        check("maddu_lo", ReadDataLo, 32'd0);
`else
        check("maddu_off_hi", ReadDataHi, 32'd0);
        check("maddu_off_lo", ReadDataLo, 32'hFFFFFFFF);
`endif
        issue(OP_MSUB, 32'd1, 32'd2);
`ifdef HI_LO_MADD_EN
        check("msub_hi", ReadDataHi, 32'd0);
        check("msub_lo", ReadDataLo, 32'hFFFFFFFE);
`else
        check("msub_off_hi", ReadDataHi, 32'd0);
        check("msub_off_lo", ReadDataLo, 32'hFFFFFFFF);
`endif

        @(negedge Clk);
        Start = 1'b1; Op = OP_MULT; A = 32'h12345678; B = 32'h100;
        @(negedge Clk);
        check("b2b_prod_hi", ReadDataHi, 32'h12);
        check("b2b_prod_lo", ReadDataLo, 32'h34567800);
        Op = OP_MTLO; A = 32'hCAFE;
        @(negedge Clk);
        Start = 1'b0;
        check("b2b_mtlo_lo", ReadDataLo, 32'hCAFE);
        check("b2b_mtlo_hi", ReadDataHi, 32'h12);

        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
